// File: rtl/fp_div_seq_if.sv
// Request/response bundle for the sequential binary32 divider.
// The requester drives the master side; the divider sits on the slave side.
interface fp_div_seq_if;
  logic        start;
  logic [31:0] fp_X;
  logic [31:0] fp_Y;
  logic [2:0]  r_mode;
  logic        busy;
  logic        done;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;
  logic        dz;
  logic        nv;

  modport master (
    output start, fp_X, fp_Y, r_mode,
    input  busy, done, fp_Z, ovrf, udrf, dz, nv
  );

  modport slave (
    input  start, fp_X, fp_Y, r_mode,
    output busy, done, fp_Z, ovrf, udrf, dz, nv
  );
endinterface

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 binary32 divider: restoring radix-2 mantissa division,
// one quotient bit per cycle, fixed 28-cycle latency from accept to done.
module fp_div_seq (
  input  logic         clk,
  input  logic         rst,
  fp_div_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        accept, iter_en, round_en, publish, busy;

  logic [7:0]  ex, ey;
  logic [22:0] fx, fy;
  logic        zx, zy, inf_x, inf_y, nan_x, nan_y, sgn;
  logic        spc;
  logic [31:0] spc_z;
  logic [3:0]  spc_fl;

  logic [24:0]        rem_q;
  logic [23:0]        div_q;
  logic [25:0]        quo_q;
  logic signed [9:0]  exp_q;
  logic               sgn_q;
  logic [2:0]         rm_q;
  logic               spc_q;
  logic [31:0]        spc_z_q;
  logic [3:0]         spc_fl_q;
  logic [31:0]        res_q;
  logic [3:0]         res_fl_q;

  logic               ge;
  logic [23:0]        rem_sub;
  logic               q25, g, r, s, up;
  logic [22:0]        frac;
  logic [23:0]        frac_r;
  logic signed [9:0]  exp_n, exp_r;
  logic [31:0]        res_d;
  logic [3:0]         res_fl_d;

  logic [31:0] fp_z_q;
  logic [3:0]  fl_q;
  logic        done_q;

  function automatic logic round_up(input logic [2:0] rm, input logic sign,
                                    input logic lsb, input logic gb,
                                    input logic rb, input logic sb);
    logic inx;
    inx = gb | rb | sb;
    case (rm)
      3'b001:  round_up = 1'b0;
      3'b010:  round_up = inx & sign;
      3'b011:  round_up = inx & ~sign;
      3'b100:  round_up = gb;
      default: round_up = gb & (rb | sb | lsb);
    endcase
  endfunction

  function automatic logic [31:0] ovf_value(input logic [2:0] rm, input logic sign);
    logic to_inf;
    case (rm)
      3'b001:  to_inf = 1'b0;
      3'b010:  to_inf = sign;
      3'b011:  to_inf = ~sign;
      default: to_inf = 1'b1;
    endcase
    ovf_value = to_inf ? {sign, 8'hFF, 23'h0} : {sign, 31'h7F7FFFFF};
  endfunction

  assign ex    = bus.fp_X[30:23];
  assign ey    = bus.fp_Y[30:23];
  assign fx    = bus.fp_X[22:0];
  assign fy    = bus.fp_Y[22:0];
  assign sgn   = bus.fp_X[31] ^ bus.fp_Y[31];
  assign zx    = (ex == 8'h00);
  assign zy    = (ey == 8'h00);
  assign inf_x = (ex == 8'hFF) && (fx == 23'h0);
  assign inf_y = (ey == 8'hFF) && (fy == 23'h0);
  assign nan_x = (ex == 8'hFF) && (fx != 23'h0);
  assign nan_y = (ey == 8'hFF) && (fy != 23'h0);

  // Special-operand outcome, flags packed as {ovrf, udrf, dz, nv}; Inf/0 is Inf/finite.
  always_comb begin
    spc    = 1'b1;
    spc_z  = 32'h0;
    spc_fl = 4'b0000;
    if (nan_x || nan_y || (zx && zy) || (inf_x && inf_y)) begin
      spc_z  = 32'h7FC00000;
      spc_fl = 4'b0001;
    end else if (inf_x) begin
      spc_z  = {sgn, 8'hFF, 23'h0};
    end else if (zy) begin
      spc_z  = {sgn, 8'hFF, 23'h0};
      spc_fl = 4'b0010;
    end else if (inf_y || zx) begin
      spc_z  = {sgn, 31'h0};
    end else begin
      spc    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = 5'd0;
        if (bus.start) state_d = DIV;
      end
      DIV: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd25) begin
          state_d = ROUND;
          cnt_d   = 5'd0;
        end
      end
      ROUND:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    accept   = (state_q == IDLE) && bus.start;
    iter_en  = (state_q == DIV);
    round_en = (state_q == ROUND);
    publish  = (state_q == DONE);
  end

  // Restoring step: remainder stays below twice the divisor, so 25 bits suffice.
  assign ge      = (rem_q >= {1'b0, div_q});
  assign rem_sub = ge ? 24'(rem_q - {1'b0, div_q}) : rem_q[23:0];

  assign q25   = quo_q[25];
  assign frac  = q25 ? quo_q[24:2] : quo_q[23:1];
  assign g     = q25 ? quo_q[1]    : quo_q[0];
  assign r     = q25 ? quo_q[0]    : 1'b0;
  assign s     = |rem_q;
  assign exp_n = q25 ? exp_q : exp_q - 10'sd1;
  assign up    = round_up(rm_q, sgn_q, frac[0], g, r, s);
  assign frac_r = {1'b0, frac} + {23'h0, up};
  assign exp_r = frac_r[23] ? exp_n + 10'sd1 : exp_n;

  always_comb begin
    res_d    = {sgn_q, exp_r[7:0], frac_r[22:0]};
    res_fl_d = 4'b0000;
    if (spc_q) begin
      res_d    = spc_z_q;
      res_fl_d = spc_fl_q;
    end else if (exp_r >= 10'sd255) begin
      res_d    = ovf_value(rm_q, sgn_q);
      res_fl_d = 4'b1000;
    end else if (exp_r <= 10'sd0) begin
      res_d    = {sgn_q, 31'h0};
      res_fl_d = 4'b0100;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rem_q    <= {2'b01, fx};
      div_q    <= {1'b1, fy};
      quo_q    <= 26'h0;
      exp_q    <= $signed({2'b00, ex}) - $signed({2'b00, ey}) + 10'sd127;
      sgn_q    <= sgn;
      rm_q     <= bus.r_mode;
      spc_q    <= spc;
      spc_z_q  <= spc_z;
      spc_fl_q <= spc_fl;
    end else if (iter_en) begin
      rem_q <= {rem_sub, 1'b0};
      quo_q <= {quo_q[24:0], ge};
    end else if (round_en) begin
      res_q    <= res_d;
      res_fl_q <= res_fl_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fp_z_q <= 32'h0;
      fl_q   <= 4'b0000;
      done_q <= 1'b0;
    end else begin
      done_q <= publish;
      if (publish) begin
        fp_z_q <= res_q;
        fl_q   <= res_fl_q;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.fp_Z = fp_z_q;
  assign bus.ovrf = fl_q[3];
  assign bus.udrf = fl_q[2];
  assign bus.dz   = fl_q[1];
  assign bus.nv   = fl_q[0];

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: hand-computed quotients, flags, latency,
// reset abort and ignored start while busy.
module tb_fp_div_seq;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_div_seq_if bus ();

  fp_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'h0, bus.ovrf, bus.udrf, bus.dz, bus.nv};
  endfunction

  // Issue one request and check latency, result, flags, pulse width and hold.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] m, input logic [31:0] ez, input logic [3:0] efl,
                        input bit intf, input bit rel);
    int lat;
    @(negedge clk);
    if (rel) rst = 1'b0;
    bus.start  = 1'b1;
    bus.fp_X   = x;
    bus.fp_Y   = y;
    bus.r_mode = m;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.fp_X  = 32'h12345678;
    bus.fp_Y  = 32'h3F800000;
    check({tag, "_busy"}, {31'h0, bus.busy}, 32'h1);
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (intf && lat == 5) begin
        bus.start  = 1'b1;
        bus.fp_X   = 32'h40C00000;
        bus.fp_Y   = 32'h40000000;
        bus.r_mode = 3'b000;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check({tag, "_lat"}, lat, 32'd28);
    check({tag, "_z"}, bus.fp_Z, ez);
    check({tag, "_flags"}, flags(), {28'h0, efl});
    @(posedge clk);
    #1;
    check({tag, "_after"}, {30'h0, bus.done, bus.busy}, 32'h0);
    check({tag, "_hold"}, bus.fp_Z, ez);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.fp_X   = 32'h0;
    bus.fp_Y   = 32'h0;
    bus.r_mode = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_z", bus.fp_Z, 32'h0);
    check("rst_flags", flags(), 32'h0);
    check("rst_ctl", {30'h0, bus.done, bus.busy}, 32'h0);

    // {ovrf, udrf, dz, nv}
    run_op("six_by_two", 32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 4'b0000, 1'b0, 1'b1);
    run_op("third_rne",  32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 4'b0000, 1'b0, 1'b0);
    run_op("third_rtz",  32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 4'b0000, 1'b0, 1'b0);
    run_op("third_rup",  32'h3F800000, 32'h40400000, 3'b011, 32'h3EAAAAAB, 4'b0000, 1'b0, 1'b0);
    run_op("third_rdn",  32'h3F800000, 32'h40400000, 3'b010, 32'h3EAAAAAA, 4'b0000, 1'b0, 1'b0);
    run_op("third_rmm",  32'h3F800000, 32'h40400000, 3'b100, 32'h3EAAAAAB, 4'b0000, 1'b0, 1'b0);
    run_op("third_m7",   32'h3F800000, 32'h40400000, 3'b111, 32'h3EAAAAAB, 4'b0000, 1'b0, 1'b0);
    run_op("nthird_rdn", 32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 4'b0000, 1'b0, 1'b0);
    run_op("nthird_rup", 32'hBF800000, 32'h40400000, 3'b011, 32'hBEAAAAAA, 4'b0000, 1'b0, 1'b0);
    run_op("div_zero",   32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 4'b0010, 1'b0, 1'b0);
    run_op("zero_zero",  32'h00000000, 32'h00000000, 3'b000, 32'h7FC00000, 4'b0001, 1'b0, 1'b0);
    run_op("nan_in",     32'h7FC00001, 32'h40000000, 3'b000, 32'h7FC00000, 4'b0001, 1'b0, 1'b0);
    run_op("inf_fin",    32'hFF800000, 32'h40000000, 3'b000, 32'hFF800000, 4'b0000, 1'b0, 1'b0);
    run_op("fin_inf",    32'h40000000, 32'h7F800000, 3'b000, 32'h00000000, 4'b0000, 1'b0, 1'b0);
    run_op("nzero_num",  32'h80000000, 32'h40000000, 3'b000, 32'h80000000, 4'b0000, 1'b0, 1'b0);
    run_op("ovf_rtz",    32'h7F7FFFFF, 32'h00800000, 3'b001, 32'h7F7FFFFF, 4'b1000, 1'b0, 1'b0);
    run_op("ovf_rne",    32'h7F7FFFFF, 32'h00800000, 3'b000, 32'h7F800000, 4'b1000, 1'b0, 1'b0);
    run_op("ovf_rup_neg",32'hFF7FFFFF, 32'h00800000, 3'b011, 32'hFF7FFFFF, 4'b1000, 1'b0, 1'b0);
    run_op("udf_pos",    32'h00800000, 32'h40000000, 3'b000, 32'h00000000, 4'b0100, 1'b0, 1'b0);
    run_op("udf_neg",    32'h80800000, 32'h40000000, 3'b000, 32'h80000000, 4'b0100, 1'b0, 1'b0);

    // Abort in DIV cycle 10.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.fp_X   = 32'h40C00000;
    bus.fp_Y   = 32'h40000000;
    bus.r_mode = 3'b000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_ctl", {30'h0, bus.done, bus.busy}, 32'h0);
    check("abort_z", bus.fp_Z, 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    dcnt = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (bus.done) dcnt++;
    end
    check("abort_nodone", dcnt, 32'd0);

    run_op("after_abort", 32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 4'b0000, 1'b0, 1'b0);
    run_op("start_busy",  32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 4'b0000, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
